// File: rtl/ornor4_sweep_ctrl.sv
// Exhaustive 4-input OR/NOR gate tester: sweeps drv through 0..15, waits SETTLE
// cycles per vector, and compares the gate outputs against the ideal OR/NOR.
module ornor4_sweep_ctrl #(
    parameter int unsigned SETTLE       = 1,
    parameter int unsigned STOP_ON_FAIL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] drv,
    input  logic       o_or_in,
    input  logic       o_nor_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [2:0] state;
    logic [3:0] vec;
    logic [3:0] cnt;
    logic       mismatch;

    // Case inequality so an X/Z from the gate under test always counts as a failure.
    assign mismatch = (o_or_in !== (|vec)) || (o_nor_in !== ~(|vec));

    assign busy = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            drv       <= 4'd0;
            vec       <= 4'd0;
            cnt       <= 4'd0;
            err_count <= 5'd0;
            fail_vec  <= 4'd0;
        end else if (abort && state != S_IDLE) begin
            state <= S_IDLE;
            drv   <= 4'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        vec       <= 4'd0;
                        drv       <= 4'd0;
                        cnt       <= 4'd0;
                        err_count <= 5'd0;
                        fail_vec  <= 4'd0;
                        state     <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    cnt   <= 4'd0;
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) state <= S_CHECK;
                    else                    cnt   <= cnt + 4'd1;
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_count != 5'd16) err_count <= err_count + 5'd1;
                        if (err_count == 5'd0)  fail_vec  <= vec;
                    end
                    // vec never wraps: vector 15 always terminates the sweep
                    if ((mismatch && STOP_ON_FAIL != 0) || vec == 4'd15) begin
                        state <= S_DONE;
                    end else begin
                        vec   <= vec + 4'd1;
                        drv   <= vec + 4'd1;
                        state <= S_APPLY;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    drv   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ornor4_sweep_ctrl.sv
// Directed bench: three controller instances (SETTLE=1 stop, SETTLE=1 no-stop,
// SETTLE=4 stop), each driving a behavioural OR/NOR gate with injectable faults.
module tb_ornor4_sweep_ctrl;

    logic       clk = 0;
    logic       rst = 0;
    logic [2:0] start = '0, abort = '0;
    logic [2:0] or_stuck = '0, nor_inv = '0;
    logic [2:0] o_or, o_nor, busy, done, pass;
    logic [3:0] drv [3];
    logic [4:0] err [3];
    logic [3:0] fv  [3];
    int         settle_of [3] = '{1, 1, 4};
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            o_or[k]  = or_stuck[k] ? 1'b0 : |drv[k];
            o_nor[k] = ~(|drv[k]) ^ nor_inv[k];
        end
    end

    ornor4_sweep_ctrl #(.SETTLE(1), .STOP_ON_FAIL(1)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .drv(drv[0]),
        .o_or_in(o_or[0]), .o_nor_in(o_nor[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(err[0]), .fail_vec(fv[0]));
    ornor4_sweep_ctrl #(.SETTLE(1), .STOP_ON_FAIL(0)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .drv(drv[1]),
        .o_or_in(o_or[1]), .o_nor_in(o_nor[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(err[1]), .fail_vec(fv[1]));
    ornor4_sweep_ctrl #(.SETTLE(4), .STOP_ON_FAIL(1)) dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .drv(drv[2]),
        .o_or_in(o_or[2]), .o_nor_in(o_nor[2]), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .err_count(err[2]), .fail_vec(fv[2]));

    task automatic pulse_start(input int k);
        @(negedge clk); start[k] = 1'b1;
        @(posedge clk); #1; start[k] = 1'b0;
    endtask

    // Edges from the start edge until done is seen; drv is predicted every cycle.
    task automatic run_sweep(input int k, output int edges, output int drv_bad);
        pulse_start(k);
        edges = 0; drv_bad = 0;
        if (drv[k] !== 4'd0 || busy[k] !== 1'b1) drv_bad++;
        while (done[k] !== 1'b1 && edges < 400) begin
            @(posedge clk); #1; edges++;
            if (done[k] !== 1'b1 && drv[k] !== 4'(edges / (settle_of[k] + 2))) drv_bad++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({drv[k], busy[k], done[k], pass[k], err[k], fv[k]} !== 16'd0) begin
                failures++;
                $display("FAIL reset[%0d] got drv=%0d busy=%b done=%b pass=%b err=%0d fv=%0d want all 0",
                         k, drv[k], busy[k], done[k], pass[k], err[k], fv[k]);
            end
        end
    endtask

    task automatic test_full_sweep;
        int e, bad;
        run_sweep(0, e, bad);
        checks++;
        if (e != 48) begin failures++; $display("FAIL s1_latency got %0d want 48", e); end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL s1_drv_seq got %0d bad cycles want 0", bad); end
        checks++;
        if ({pass[0], err[0], fv[0], drv[0]} !== {1'b1, 5'd0, 4'd0, 4'd15}) begin
            failures++;
            $display("FAIL s1_result got pass=%b err=%0d fv=%0d drv=%0d want 1/0/0/15",
                     pass[0], err[0], fv[0], drv[0]);
        end
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({done[0], busy[0], pass[0], drv[0]} !== {1'b1, 1'b0, 1'b1, 4'd15}) begin
            failures++;
            $display("FAIL s1_done_hold got done=%b busy=%b pass=%b drv=%0d want 1/0/1/15",
                     done[0], busy[0], pass[0], drv[0]);
        end
    endtask

    task automatic test_stop_on_fail;
        int e, bad;
        or_stuck[0] = 1'b1;
        run_sweep(0, e, bad);
        or_stuck[0] = 1'b0;
        checks++;
        if (e != 6) begin failures++; $display("FAIL s2_latency got %0d want 6", e); end
        checks++;
        if ({pass[0], err[0], fv[0], drv[0]} !== {1'b0, 5'd1, 4'd1, 4'd1}) begin
            failures++;
            $display("FAIL s2_result got pass=%b err=%0d fv=%0d drv=%0d want 0/1/1/1",
                     pass[0], err[0], fv[0], drv[0]);
        end
    endtask

    task automatic test_saturate;
        int e, bad;
        nor_inv[1] = 1'b1;
        run_sweep(1, e, bad);
        checks++;
        if (e != 48 || bad != 0) begin
            failures++; $display("FAIL s3_latency got %0d (bad=%0d) want 48 (0)", e, bad);
        end
        checks++;
        if ({pass[1], err[1], fv[1]} !== {1'b0, 5'd16, 4'd0}) begin
            failures++;
            $display("FAIL s3_result got pass=%b err=%0d fv=%0d want 0/16/0", pass[1], err[1], fv[1]);
        end
    endtask

    task automatic test_mid_reset;
        pulse_start(1);
        repeat (21) @(posedge clk);
        #1;
        checks++;
        if ({drv[1], err[1]} !== {4'd7, 5'd7}) begin
            failures++; $display("FAIL s4_pre got drv=%0d err=%0d want 7/7", drv[1], err[1]);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        checks++;
        if ({drv[1], busy[1], done[1], pass[1], err[1], fv[1]} !== 16'd0) begin
            failures++;
            $display("FAIL s4_reset got drv=%0d busy=%b done=%b pass=%b err=%0d fv=%0d want all 0",
                     drv[1], busy[1], done[1], pass[1], err[1], fv[1]);
        end
        pulse_start(1);
        checks++;
        if ({drv[1], busy[1], err[1]} !== {4'd0, 1'b1, 5'd0}) begin
            failures++; $display("FAIL s4_restart got drv=%0d busy=%b err=%0d want 0/1/0", drv[1], busy[1], err[1]);
        end
    endtask

    task automatic test_abort_priority;
        // dut1 still sweeping with inverted NOR: two vectors checked by edge 6
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (err[1] !== 5'd2) begin failures++; $display("FAIL abort_pre_err got %0d want 2", err[1]); end
        @(negedge clk); abort[1] = 1'b1; start[1] = 1'b1;
        @(posedge clk); #1; abort[1] = 1'b0; start[1] = 1'b0;
        checks++;
        if ({busy[1], done[1], drv[1], err[1], fv[1]} !== {1'b0, 1'b0, 4'd0, 5'd2, 4'd0}) begin
            failures++;
            $display("FAIL abort_over_start got busy=%b done=%b drv=%0d err=%0d fv=%0d want 0/0/0/2/0",
                     busy[1], done[1], drv[1], err[1], fv[1]);
        end
        nor_inv[1] = 1'b0;
    endtask

    task automatic test_back_to_back;
        int seen_done = 0;
        pulse_start(0);
        for (int e = 1; e <= 15; e++) begin
            @(negedge clk); start[0] = (e == 4);
            @(posedge clk); #1;
        end
        start[0] = 1'b0;
        checks++;
        if ({drv[0], busy[0]} !== {4'd5, 1'b1}) begin
            failures++; $display("FAIL s5_timing got drv=%0d busy=%b want 5/1", drv[0], busy[0]);
        end
        @(negedge clk); abort[0] = 1'b1;
        @(posedge clk); #1; abort[0] = 1'b0;
        checks++;
        if ({busy[0], done[0], drv[0], err[0]} !== {1'b0, 1'b0, 4'd0, 5'd0}) begin
            failures++;
            $display("FAIL s5_abort got busy=%b done=%b drv=%0d err=%0d want 0/0/0/0",
                     busy[0], done[0], drv[0], err[0]);
        end
        repeat (60) begin
            @(posedge clk); #1;
            if (done[0] === 1'b1 || drv[0] !== 4'd0) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin failures++; $display("FAIL s5_idle_hold got %0d bad cycles want 0", seen_done); end
    endtask

    task automatic test_long_settle;
        int e, bad;
        run_sweep(2, e, bad);
        checks++;
        if (e != 96 || bad != 0) begin
            failures++; $display("FAIL s6_latency got %0d (bad=%0d) want 96 (0)", e, bad);
        end
        checks++;
        if ({pass[2], err[2], fv[2]} !== {1'b1, 5'd0, 4'd0}) begin
            failures++; $display("FAIL s6_result got pass=%b err=%0d fv=%0d want 1/0/0", pass[2], err[2], fv[2]);
        end
        or_stuck[2] = 1'b1;
        run_sweep(2, e, bad);
        or_stuck[2] = 1'b0;
        checks++;
        if (e != 12 || {err[2], fv[2]} !== {5'd1, 4'd1}) begin
            failures++;
            $display("FAIL s6_fault got edges=%0d err=%0d fv=%0d want 12/1/1", e, err[2], fv[2]);
        end
        pulse_start(2);
        checks++;
        if ({busy[2], done[2], drv[2], err[2], fv[2]} !== {1'b1, 1'b0, 4'd0, 5'd0, 4'd0}) begin
            failures++;
            $display("FAIL s6_restart got busy=%b done=%b drv=%0d err=%0d fv=%0d want 1/0/0/0/0",
                     busy[2], done[2], drv[2], err[2], fv[2]);
        end
    endtask

    initial begin
        test_reset;
        test_full_sweep;
        test_stop_on_fail;
        test_saturate;
        test_mid_reset;
        test_abort_priority;
        test_back_to_back;
        test_long_settle;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ornor4_sweep_ctrl.md
ORNOR4_SWEEP_CTRL -- requirements
Module: ornor4_sweep_ctrl

Interface
REQ-001 The module SHALL have parameter SETTLE, default 1, giving the number of wait cycles between applying a vector and checking it (legal range 1..15).
REQ-002 The module SHALL have parameter STOP_ON_FAIL, default 1: 1 = end the sweep at the first mismatch, 0 = sweep all 16 vectors.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: request to begin a sweep.
REQ-006 The module SHALL have port abort, input, 1 bit: cancel the running sweep.
REQ-007 The module SHALL have port drv, output, 4 bits: stimulus to the gate under test, drv[0..3] to I0..I3.
REQ-008 The module SHALL have port o_or_in, input, 1 bit: O_OR of the gate under test.
REQ-009 The module SHALL have port o_nor_in, input, 1 bit: O_NOR of the gate under test.
REQ-010 The module SHALL have port busy, output, 1 bit: high in APPLY, SETTLE and CHECK.
REQ-011 The module SHALL have port done, output, 1 bit: high while in DONE.
REQ-012 The module SHALL have port pass, output, 1 bit: in DONE, 1 if err_count == 0.
REQ-013 The module SHALL have port err_count, output, 5 bits: number of mismatching vectors, 0..16.
REQ-014 The module SHALL have port fail_vec, output, 4 bits: first vector that mismatched; 0 if none.

Function
REQ-015 The FSM SHALL have states IDLE, APPLY, SETTLE, CHECK and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL clear err_count, fail_vec and the vector index, and go to APPLY with vector 0.
REQ-017 start SHALL be ignored in APPLY, SETTLE and CHECK.
REQ-018 APPLY SHALL last 1 cycle with drv = current vector, then go to SETTLE.
REQ-019 SETTLE SHALL last exactly SETTLE cycles, then go to CHECK.
REQ-020 drv SHALL be held constant from APPLY through CHECK of the same vector.
REQ-021 CHECK SHALL last 1 cycle and compare against expected values sampled in that cycle: o_or_in vs |vec and o_nor_in vs ~|vec.
REQ-022 A mismatch SHALL be flagged if either output differs from its expected value, including X or Z, which always count as a mismatch.
REQ-023 On a mismatch, err_count SHALL increment by 1, saturating at 16.
REQ-024 On the first mismatch of a sweep only, fail_vec SHALL be loaded with the current vector.
REQ-025 After CHECK, the FSM SHALL go to DONE if (mismatch and STOP_ON_FAIL=1) or the vector is 15; otherwise it SHALL increment the vector and go to APPLY.
REQ-026 The 4-bit vector index SHALL never wrap: the sweep ends at 15.
REQ-027 Each vector SHALL take exactly SETTLE+2 cycles.
REQ-028 For a full sweep, done SHALL rise 16*(SETTLE+2) rising edges after the edge that sampled start.
REQ-029 DONE SHALL persist until start, abort or rst.
REQ-030 pass, err_count and fail_vec SHALL be stable in DONE.
REQ-031 In DONE, drv SHALL hold the last vector applied.
REQ-032 abort=1 in any state other than IDLE SHALL force IDLE on the next edge, with drv=0 and done=0; err_count and fail_vec SHALL be left unchanged.
REQ-033 abort SHALL have priority over start in the same cycle.
REQ-034 In IDLE, drv SHALL be 0 and busy=done=0.

Reset
REQ-035 rst SHALL have priority over abort and start.
REQ-036 On rst (including mid-sweep), the next edge SHALL set: state=IDLE, drv=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, vector index=0.

Verification
REQ-037 Scenario 1: correct OR/NOR model, SETTLE=1, start pulsed -> done rises 48 edges later; pass=1, err_count=0, fail_vec=0; drv steps 0..15, each held for 3 cycles.
REQ-038 Scenario 2: o_or_in stuck at 0, STOP_ON_FAIL=1 -> done rises 6 edges after start; err_count=1, fail_vec=4'b0001, pass=0.
REQ-039 Scenario 3: o_nor_in inverted on all vectors, STOP_ON_FAIL=0 -> done after 48 edges; err_count=16 (saturation reached, no wrap), fail_vec=0.
REQ-040 Scenario 4: rst asserted during vector 7 -> next cycle IDLE, all outputs 0; a new start restarts at vector 0.
REQ-041 Scenario 5: start re-pulsed while busy -> ignored, sweep timing unchanged; abort at vector 5 -> IDLE next cycle, done never asserts, drv=0.
REQ-042 Scenario 6: SETTLE=4, correct model -> done after 96 edges, pass=1; start pulsed in DONE -> counters clear and a new sweep begins at vector 0.
